// File: rtl/qsweep_pkg.sv
// Shared types and default widths for the query sweep sequencer.
package qsweep_pkg;
  localparam int QSWEEP_QBITS = 7;
  localparam int QSWEEP_DBITS = 8;
  localparam int CNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;
endpackage

// File: rtl/qsweep_dwell_timer.sv
// Dwell counter: cleared while not settling, counts while enabled, flags DWELL-1.
module qsweep_dwell_timer
  import qsweep_pkg::*;
#(
  parameter int DWELL = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Counter register with clear priority over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Terminal count is only meaningful while the count is running.
  always_comb begin
    tc = 1'b0;
    if (enable && (cnt_r == TC_VAL)) begin
      tc = 1'b1;
    end else begin
      tc = 1'b0;
    end
  end
endmodule

// File: rtl/query_sweep_sequencer.sv
// Drives queries into a lookup block, waits DWELL cycles per query and hands
// each (query, result) pair to a consumer over valid/ready.
module query_sweep_sequencer
  import qsweep_pkg::*;
#(
  parameter int QBITS   = QSWEEP_QBITS,
  parameter int DBITS   = QSWEEP_DBITS,
  parameter int DWELL   = 64,
  parameter int FIRST_Q = 0,
  parameter int LAST_Q  = 127
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             single,
  input  logic [QBITS-1:0] single_query,
  input  logic             abort,
  output logic [QBITS-1:0] query_out,
  input  logic [DBITS-1:0] dut_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [QBITS-1:0] res_query,
  output logic [DBITS-1:0] res_data,
  output logic             busy,
  output logic             done
);
  localparam logic [QBITS-1:0] FIRST_QV = QBITS'(FIRST_Q);
  localparam logic [QBITS-1:0] LAST_QV  = QBITS'(LAST_Q);
  localparam logic [QBITS-1:0] Q_ONE    = {{(QBITS-1){1'b0}}, 1'b1};

  state_t state_r;
  logic   single_r;
  logic   clear_s;
  logic   enable_s;
  logic   tc_s;

  // The counter only runs in SETTLE, so it is always zero on entry.
  always_comb begin
    clear_s  = 1'b1;
    enable_s = 1'b0;
    if (state_r == SETTLE) begin
      clear_s  = 1'b0;
      enable_s = 1'b1;
    end else begin
      clear_s  = 1'b1;
      enable_s = 1'b0;
    end
  end

  qsweep_dwell_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .enable(enable_s),
    .tc    (tc_s)
  );

  // Sequencer FSM with all outputs registered; abort beats a handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      single_r  <= 1'b0;
      query_out <= {QBITS{1'b0}};
      res_valid <= 1'b0;
      res_query <= {QBITS{1'b0}};
      res_data  <= {DBITS{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            single_r  <= single;
            query_out <= single ? single_query : FIRST_QV;
            busy      <= 1'b1;
            state_r   <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else if (tc_s) begin
            res_data  <= dut_result;
            res_query <= query_out;
            res_valid <= 1'b1;
            state_r   <= HOLD;
          end
        end
        HOLD: begin
          if (abort) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            if (single_r || (query_out == LAST_QV)) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= IDLE;
            end else begin
              query_out <= query_out + Q_ONE;
              state_r   <= SETTLE;
            end
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_query_sweep_sequencer.sv
// Scoreboard bench: a default-parameter sequencer and a DWELL=1, 126..127 boundary instance.
module tb_query_sweep_sequencer;
  typedef struct {
    logic [6:0] q;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  function automatic logic [7:0] lookup(input logic [6:0] q);
    return ~{1'b0, q};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic       start_a, single_a, abort_a, res_ready_a;
  logic [6:0] single_query_a, query_out_a, res_query_a;
  logic [7:0] dut_result_a, res_data_a;
  logic       res_valid_a, busy_a, done_a;

  logic       start_b, single_b, abort_b, res_ready_b;
  logic [6:0] single_query_b, query_out_b, res_query_b;
  logic [7:0] dut_result_b, res_data_b;
  logic       res_valid_b, busy_b, done_b;

  assign dut_result_a = lookup(query_out_a);
  assign dut_result_b = lookup(query_out_b);

  query_sweep_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .single(single_a),
    .single_query(single_query_a), .abort(abort_a), .query_out(query_out_a),
    .dut_result(dut_result_a), .res_valid(res_valid_a), .res_ready(res_ready_a),
    .res_query(res_query_a), .res_data(res_data_a), .busy(busy_a), .done(done_a)
  );

  query_sweep_sequencer #(.DWELL(1), .FIRST_Q(126), .LAST_Q(127)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .single(single_b),
    .single_query(single_query_b), .abort(abort_b), .query_out(query_out_b),
    .dut_result(dut_result_b), .res_valid(res_valid_b), .res_ready(res_ready_b),
    .res_query(res_query_b), .res_data(res_data_b), .busy(busy_b), .done(done_b)
  );

  exp_t sc_a[$];
  exp_t sc_b[$];
  exp_t e_a, e_b;
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;

  // Monitor A: pop and compare on every handshake
  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (!reset && !abort_a && res_valid_a && res_ready_a) begin
      if (sc_a.size() == 0) check("a_unexpected_result", 32'd1, 32'd0);
      else begin
        e_a = sc_a.pop_front();
        check("a_res_query", res_query_a, e_a.q);
        check("a_res_data", res_data_a, e_a.d);
        check("a_query_out_held", query_out_a, e_a.q);
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (done_b) done_cnt_b++;
    if (!reset && !abort_b && res_valid_b && res_ready_b) begin
      if (sc_b.size() == 0) check("b_unexpected_result", 32'd1, 32'd0);
      else begin
        e_b = sc_b.pop_front();
        check("b_res_query", res_query_b, e_b.q);
        check("b_res_data", res_data_b, e_b.d);
      end
    end
  end

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_query_out"}, query_out_a, 32'd0);
    check({tag, "_res_valid"}, res_valid_a, 32'd0);
    check({tag, "_res_query"}, res_query_a, 32'd0);
    check({tag, "_res_data"}, res_data_a, 32'd0);
    check({tag, "_busy"}, busy_a, 32'd0);
    check({tag, "_done"}, done_a, 32'd0);
  endtask

  initial begin
    int s;
    int n;
    int dc;
    reset = 1'b1;
    start_a = 1'b0; single_a = 1'b0; single_query_a = 7'd0; abort_a = 1'b0; res_ready_a = 1'b1;
    start_b = 1'b0; single_b = 1'b0; single_query_b = 7'd0; abort_b = 1'b0; res_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_a("rst_a");
    check("rst_b_query_out", query_out_b, 32'd0);
    check("rst_b_busy", busy_b, 32'd0);
    reset = 1'b0;

    // Boundary instance: DWELL=1, two queries
    sc_b.push_back(exp_t'{q: 7'd126, d: lookup(7'd126)});
    sc_b.push_back(exp_t'{q: 7'd127, d: lookup(7'd127)});
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    check("b_first_query", query_out_b, 32'd126);
    check("b_valid_before_sample", res_valid_b, 32'd0);
    check("b_busy", busy_b, 32'd1);
    @(posedge clk); #1;
    check("b_valid_q126", res_valid_b, 32'd1);
    @(posedge clk); #1;
    check("b_valid_dropped", res_valid_b, 32'd0);
    check("b_second_query", query_out_b, 32'd127);
    @(posedge clk); #1;
    check("b_valid_q127", res_valid_b, 32'd1);
    @(posedge clk); #1;
    check("b_done", done_b, 32'd1);
    check("b_busy_at_done", busy_b, 32'd0);
    check("b_query_no_wrap", query_out_b, 32'd127);
    @(posedge clk); #1;
    check("b_done_one_cycle", done_b, 32'd0);
    check("b_queue_empty", sc_b.size(), 32'd0);
    check("b_done_count", done_cnt_b, 32'd1);

    // Full default sweep
    for (int k = 0; k < 128; k++) sc_a.push_back(exp_t'{q: 7'(k), d: lookup(7'(k))});
    pulse_start_a();
    s = cyc;
    n = 0;
    while (!done_a && n < 9000) begin
      if (((cyc - s) % 65) == 0) check("a_query_step", query_out_a, 32'((cyc - s) / 65));
      @(posedge clk); #1;
      n++;
    end
    check("a_sweep_latency", cyc - s, 32'd8320);
    check("a_busy_at_done", busy_a, 32'd0);
    check("a_sweep_queue_empty", sc_a.size(), 32'd0);
    @(posedge clk); #1;
    check("a_done_one_cycle", done_a, 32'd0);
    check("a_done_count_sweep", done_cnt_a, 32'd1);

    // Single directed query
    single_a = 1'b1; single_query_a = 7'h2A;
    sc_a.push_back(exp_t'{q: 7'h2A, d: lookup(7'h2A)});
    pulse_start_a();
    single_a = 1'b0; single_query_a = 7'h11;
    s = cyc;
    n = 0;
    while (!res_valid_a && n < 200) begin @(posedge clk); #1; n++; end
    check("a_single_sample_latency", cyc - s, 32'd64);
    @(posedge clk); #1;
    check("a_single_done", done_a, 32'd1);
    check("a_single_query_kept", query_out_a, 32'h2A);
    check("a_single_busy", busy_a, 32'd0);

    // Backpressure at query 5, then abort at query 40
    for (int k = 0; k < 40; k++) sc_a.push_back(exp_t'{q: 7'(k), d: lookup(7'(k))});
    pulse_start_a();
    n = 0;
    while (!(res_valid_a && res_query_a == 7'd5) && n < 1000) begin @(posedge clk); #1; n++; end
    check("a_reach_q5", res_query_a, 32'd5);
    res_ready_a = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("bp_res_valid", res_valid_a, 32'd1);
      check("bp_res_query", res_query_a, 32'd5);
      check("bp_res_data", res_data_a, 32'(lookup(7'd5)));
      check("bp_query_out", query_out_a, 32'd5);
    end
    @(posedge clk); #1 res_ready_a = 1'b1;
    n = 0;
    while (!(query_out_a == 7'd40 && !res_valid_a) && n < 3000) begin @(posedge clk); #1; n++; end
    check("a_reach_q40", query_out_a, 32'd40);
    dc = done_cnt_a;
    repeat (10) @(posedge clk);
    #1 abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    check("abort_busy", busy_a, 32'd0);
    check("abort_valid", res_valid_a, 32'd0);
    check("abort_done", done_a, 32'd0);
    check("abort_query_kept", query_out_a, 32'd40);
    check("abort_res_query_kept", res_query_a, 32'd39);
    check("abort_queue_empty", sc_a.size(), 32'd0);
    repeat (5) @(posedge clk);
    #1 check("abort_no_done", done_cnt_a, 32'(dc));

    // Restart, ignored start while busy, reset in HOLD
    res_ready_a = 1'b0;
    pulse_start_a();
    check("restart_query0", query_out_a, 32'd0);
    check("restart_busy", busy_a, 32'd1);
    single_a = 1'b1; single_query_a = 7'h55; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; single_a = 1'b0;
    check("start_ignored_settle", query_out_a, 32'd0);
    n = 0;
    while (!res_valid_a && n < 200) begin @(posedge clk); #1; n++; end
    check("hold_res_query", res_query_a, 32'd0);
    check("hold_res_data", res_data_a, 32'(lookup(7'd0)));
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    check("start_ignored_hold", res_valid_a, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check_zero_a("hold_rst");
    res_ready_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_after_reset", busy_a, 32'd0);

    // start and abort together in IDLE: start wins
    start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b0;
    check("start_beats_abort", busy_a, 32'd1);
    abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    check("abort_cleanup", busy_a, 32'd0);
    check("final_queue_empty", sc_a.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/query_sweep_sequencer.md
Name: query_sweep_sequencer

Overview:
- Sequences a query-driven lookup user module whose interface is a 7-bit query and an 8-bit result.
- Drives each query value and holds it stable for a programmable dwell time.
- Samples the module's result, then hands the (query, result) pair to a consumer over a valid/ready handshake.
- Supports a full sweep (FIRST_Q..LAST_Q) or a single directed query. Sits between the lookup module and the capture/readout logic.

Parameters:
- QBITS, 7, query width.
- DBITS, 8, result width.
- DWELL, 64, cycles each query is held before sampling; legal range 1..2^16-1.
- FIRST_Q, 0, first query of a sweep.
- LAST_Q, 127, last query of a sweep; must be >= FIRST_Q.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin operation; sampled only in IDLE.
- single  in  1  sampled with start: 1 = single query, 0 = sweep.
- single_query  in  QBITS  query used when single=1; captured at start.
- abort  in  1  synchronous cancel.
- query_out  out  QBITS  query driven to the lookup module.
- dut_result  in  DBITS  result from the lookup module.
- res_valid  out  1  a result is available.
- res_ready  in  1  consumer accepts the result.
- res_query  out  QBITS  query associated with res_data.
- res_data  out  DBITS  sampled result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state=IDLE; query_out=0, res_valid=0, res_query=0, res_data=0, busy=0, done=0; dwell counter=0. reset has priority over all other inputs.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - On start=1, latch the mode.
  - query_out <= single ? single_query : FIRST_Q.
  - Counter <= 0; go to SETTLE.
  - start is ignored in all other states.
- SETTLE:
  - Counter increments each cycle; query_out is held constant.
  - When counter==DWELL-1, at that edge: res_data <= dut_result, res_query <= query_out, res_valid <= 1; go to HOLD.
  - Result: query_out is stable for exactly DWELL cycles before the sample edge. With DWELL=1, sampling occurs on the first SETTLE edge.
- HOLD:
  - res_valid stays high; res_data, res_query and query_out are held until res_valid&&res_ready at an edge.
  - On that handshake, res_valid <= 0, then:
    - if single mode, or query_out==LAST_Q: done <= 1 for one cycle; go to IDLE.
    - else: query_out <= query_out+1, counter <= 0; go to SETTLE.
- Throughput: with res_ready tied high, one result per DWELL+1 cycles. A default sweep takes 128*65 = 8320 cycles from start to done.
- No wrap-around: query_out never increments past LAST_Q.
- Arithmetic: query increment is QBITS wide. The counter is 16 bits and compares against DWELL-1.
- abort=1 in any non-IDLE state: next cycle state=IDLE, res_valid=0, done stays 0; query_out, res_query and res_data keep their values. abort in IDLE has no effect.
- Simultaneous events:
  - abort and a handshake in the same cycle: abort wins, no done.
  - start and abort in IDLE: start is honoured.
- Reset mid-sweep returns all outputs to reset values on the next edge.
- res_ready high while res_valid=0 has no effect.
- busy is high in SETTLE and HOLD, and low in the cycle done is high.

Decomposition:
- Shared package qsweep_pkg:
  - state enum {IDLE, SETTLE, HOLD};
  - default width constants QBITS/DBITS;
  - counter width constant CNT_W=16.
- One natural sub-module: qsweep_dwell_timer. It holds the clear/enable counter and produces the terminal-count pulse at DWELL-1.
- The FSM and output registers stay in the top module.

Test Plan:
- Default sweep, res_ready=1, lookup model result=~query: 128 handshakes in order, res_query 0..127 with res_data=~res_query. Single done pulse 8320 cycles after start. query_out steps every 65 cycles.
- Single query, single=1, single_query=7'h2A, DWELL=64: one result with res_query=7'h2A after 64 cycles in SETTLE. done on the handshake cycle; query_out stays 7'h2A.
- Backpressure: res_ready=0 for 20 cycles at query 5. res_valid, res_data, res_query and query_out are all held for those 20 cycles. query 6 appears only after the handshake, with no lost or duplicated results.
- Abort at query 40 mid-SETTLE: IDLE next cycle, res_valid=0, no done. A following start restarts the sweep at query 0.
- Synchronous reset asserted during HOLD: all outputs zero on the next edge. start pulsed during busy is ignored.
- Boundaries: DWELL=1, FIRST_Q=126, LAST_Q=127 gives exactly 2 results, each 1 cycle after its query change. Sampled value equals dut_result at the sample edge.
